// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream adapter and its output buffer.
package fifo_pkg;

    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned RD_BUF_DEPTH    = 2;
    localparam int unsigned CNT_W           = $clog2(RD_BUF_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_stream_reader.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import fifo_pkg::*;

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    cnt_t                  level;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, level
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, level
    );

endinterface

// File: rtl/stream_buf2.sv
// Two-entry in-order buffer; a pop shifts out the head before a push appends.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output cnt_t                  count
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic [DATA_WIDTH-1:0] slot_d [2];
    cnt_t                  count_q, count_d;
    cnt_t                  fill;

    always_comb begin
        slot_d  = slot_q;
        fill    = count_q - {{(CNT_W-1){1'b0}}, pop};
        if (pop) begin
            slot_d[0] = slot_q[1];
        end
        // Append lands in the first slot left free after the pop.
        if (push) begin
            if (fill == '0) begin
                slot_d[0] = push_data;
            end else begin
                slot_d[1] = push_data;
            end
        end
        count_d = fill + {{(CNT_W-1){1'b0}}, push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= '0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            count_q   <= count_d;
        end
    end

    assign head  = slot_q[0];
    assign count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream without bubbles.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_stream_reader_if.master bus
);

    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  rd_en;
    cnt_t                  count;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_W:0]        occ_now;
    logic [CNT_W:0]        occ_next;

    // Reads are only issued when a capture slot is guaranteed; m_ready feeds rd_en directly.
    always_comb begin
        pop        = (count != '0) && bus.m_ready;
        occ_now    = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        occ_next   = occ_now - {{CNT_W{1'b0}}, pop};
        rd_en      = rst_n && !bus.fifo_empty && (occ_next < (CNT_W+1)'(RD_BUF_DEPTH));
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.m_valid    = (count != '0);
        bus.m_data     = head;
        bus.level      = count;
    end

    occupancy_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        occ_now <= (CNT_W+1)'(RD_BUF_DEPTH));

    no_capture_into_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && !pop && (count == CNT_W'(RD_BUF_DEPTH))));

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains a synchronous FIFO and presents its contents as a valid/ready stream. The FIFO has one cycle of read latency: `rd_en` is sampled at a clock edge, and the popped word appears on `dout` after that edge. This block issues `rd_en`, tracks the in-flight read, and captures each word into a 2-entry output buffer. It sits between any FIFO with that read interface and a downstream consumer, and sustains one word per cycle with no bubbles.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO's `DATA_WIDTH`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data; valid in the cycle after a pop.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `m_valid`  out  1  the output buffer head holds a word.
- `m_ready`  in  1  consumer accepts the head word this cycle.
- `m_data`  out  DATA_WIDTH  head word; registered, held stable while `m_valid && !m_ready`.
- `level`  out  2  buffer occupancy (0..2), excluding the in-flight read.

## Operation
- **State:**
  - `count` (0..2) is the buffer occupancy.
  - `inflight` (1 bit) means a pop was issued last cycle, so `fifo_dout` carries valid data this cycle.
  - `buf[0..1]` holds the words; `buf[0]` is the head.
- **Pop condition:** `pop = m_valid && m_ready`.
- **Read issue (combinational):** `fifo_rd_en = rst_n && !fifo_empty && (count + inflight - pop) < 2`.
  - This guarantees a capture slot always exists.
  - There is a deliberate combinational path from `m_ready` to `fifo_rd_en`.
- **Next in-flight state:** `inflight_next = fifo_rd_en`.
- **Capture:** if `inflight`, `fifo_dout` is written into the first free slot after the pop is applied.
  - Order at the edge is: shift out on pop, then append the capture.
  - Simultaneous pop and capture leave `count` unchanged.
- **Output:** `m_valid = (count != 0)`, `m_data = buf[0]`, `level = count`.
- **Ordering:** words leave in FIFO order; no word is dropped or duplicated.
- **Invariant:** `count + inflight <= 2` at every edge. A capture into a full buffer is an assertion failure.
- **Reset:**
  - `count = 0`, `inflight = 0`, `buf = 0`.
  - Outputs are `m_valid = 0`, `m_data = 0`, `level = 0`, `fifo_rd_en = 0`.
  - A mid-operation reset discards buffered and in-flight words.
  - The FIFO must be reset in the same cycle, otherwise popped words are lost; the integration owns this requirement.

## Timing
- **Latency:** with `count = 0`, a word reaches the output 2 cycles after the pop.
  - Cycle N: `fifo_rd_en = 1` is sampled.
  - Cycle N+1: `inflight = 1`, `fifo_dout` is valid.
  - Cycle N+2: `m_valid = 1` with that word.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, steady state is `count = 1`, `inflight = 1`, one pop and one read per cycle.
- **Backpressure:** with `m_ready = 0`, reads stop once `count + inflight = 2`; at most 2 words are held.
- **Empty FIFO:** `fifo_rd_en = 0`. An in-flight word is still captured.
- **Hold rule:** `m_valid` never deasserts without a pop. `m_data` changes only on a pop or on a capture into an empty buffer.
- **Simultaneous events:** the FIFO going empty in the same cycle as a capture and a pop raises no special case; the rules above apply unchanged.

## Structure
- Shared package/header `fifo_pkg`:
  - `FIFO_RD_LATENCY = 1`.
  - `RD_BUF_DEPTH = 2`.
  - Width macro for the occupancy counter (`$clog2(RD_BUF_DEPTH+1)`).
- One sub-module, `stream_buf2`:
  - A 2-entry in-order buffer with ports `push`/`push_data`, `pop`, `head`, `count`.
  - Async active-low reset.
  - Also intended for reuse on other stream paths.
- Top level holds only the `inflight` flop, the `fifo_rd_en` equation and the assertions.

## Test plan
1. **Reset defaults:** hold `rst_n = 0` with a non-empty FIFO → `fifo_rd_en = 0`, `m_valid = 0`, `m_data = 0`, `level = 0`. Release → first `fifo_rd_en = 1` appears in the same cycle.
2. **Single-word latency:** write 8'h01 into an empty depth-2 FIFO (`ADDR_WIDTH = 1`) with `m_ready = 1` → `m_valid = 1` with `m_data = 8'h01` exactly 2 cycles after `fifo_rd_en`, for one cycle, then `m_valid = 0`.
3. **Streaming:** writer pushes 1..10 back-to-back with `m_ready = 1` → the consumer receives 1..10 in order, one per cycle after the initial 2-cycle latency, with no gaps while the FIFO is non-empty.
4. **Backpressure:** FIFO holds 1,2,3,4 and `m_ready = 0` → `level` settles at 2 with `m_data = 1`, `fifo_rd_en = 0`, and the FIFO retains 3,4. Raise `m_ready` → 1,2,3,4 are delivered in order.
5. **Toggling ready:** random `m_ready` over 100 words → a scoreboard shows no loss, duplication or reordering; `m_data` is stable while `m_valid && !m_ready`; the `count + inflight <= 2` assertion never fires.
6. **Mid-stream reset:** assert `rst_n` low while `inflight = 1` and `level = 2`, resetting the FIFO too → all outputs return to reset values in the same cycle with no clock edge needed. After release, new words 8'hA0, 8'hA1 stream correctly.
